// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop driver: op codes, FSM states and
// the expected-Q rule used by the shadow model.
package jk_pkg;

   localparam logic [2:0] JK_OP_HOLD   = 3'd0;
   localparam logic [2:0] JK_OP_RESET  = 3'd1;
   localparam logic [2:0] JK_OP_SET    = 3'd2;
   localparam logic [2:0] JK_OP_TOGGLE = 3'd3;
   localparam logic [2:0] JK_OP_PRESET = 3'd4;
   localparam logic [2:0] JK_OP_CLEAR  = 3'd5;

   localparam int JK_CNT_W = 4;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_STROBE = 3'd3,
      ST_ASYNC  = 3'd4,
      ST_SETTLE = 3'd5,
      ST_CHECK  = 3'd6,
      ST_RESP   = 3'd7
   } jk_state_e;

   // Expected flip-flop output after applying op to current Q.
   function automatic logic jk_next(input logic [2:0] op, input logic q);
      logic r;
      r = q;
      case (op)
         JK_OP_HOLD:   r = q;
         JK_OP_RESET:  r = 1'b0;
         JK_OP_SET:    r = 1'b1;
         JK_OP_TOGGLE: r = ~q;
         JK_OP_PRESET: r = 1'b1;
         JK_OP_CLEAR:  r = 1'b0;
         default:      r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_ff.sv
// Behavioural JK flip-flop with active-low clock and active-low async
// preset/clear (clear wins if both are asserted).
module jk_ff (
   input  logic clk_n,
   input  logic j,
   input  logic k,
   input  logic preset_n,
   input  logic clear_n,
   output logic q,
   output logic qn
);

   // State changes on the falling clock strobe or an asserted preset/clear.
   always_ff @(negedge clk_n or negedge preset_n or negedge clear_n) begin
      if (!clear_n)       q <= 1'b0;
      else if (!preset_n) q <= 1'b1;
      else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

   assign qn = ~q;

endmodule

// File: rtl/jk_ff_driver.sv
// Command sequencer for one active-low JK flip-flop. Each accepted command
// drives J/K and a clock strobe (or an async preset/clear pulse), waits for
// the device to settle, samples Q/QN and reports status against a shadow Q.
// All pin and status outputs are registered from the next-state decode, so
// they line up exactly with the state they belong to.
module jk_ff_driver
   import jk_pkg::*;
#(
   parameter int PULSE_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 1,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [2:0]           cmd_op_i,
   output logic                 jk_j_o,
   output logic                 jk_k_o,
   output logic                 jk_clk_o,
   output logic                 jk_preset_o,
   output logic                 jk_clear_o,
   input  logic                 jk_q_i,
   input  logic                 jk_qn_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic                 rsp_q_o,
   output logic                 rsp_err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam logic [JK_CNT_W-1:0] PULSE_LD  = JK_CNT_W'(PULSE_CYCLES);
   localparam logic [JK_CNT_W-1:0] SETTLE_LD = JK_CNT_W'(SETTLE_CYCLES);

   jk_state_e            state, state_nx;
   logic [JK_CNT_W-1:0]  cnt, cnt_nx;
   logic [2:0]           op, op_nx;
   logic                 exp_q, exp_q_nx;
   logic                 term, accept, illegal;

   logic                 j_nx, k_nx, clk_nx, preset_nx, clear_nx;
   logic                 ready_nx, rsp_valid_nx, rsp_q_nx, rsp_err_nx;
   logic [ERR_CNT_W-1:0] err_cnt_nx;
   logic                 jk_drive;

   assign term    = (cnt == JK_CNT_W'(1));
   assign accept  = cmd_valid_i & cmd_ready_o;
   assign illegal = (cmd_op_i > JK_OP_CLEAR);

   // Next state, pulse/settle down-counter and latched op.
   always_comb begin
      state_nx = state;
      cnt_nx   = (cnt > JK_CNT_W'(1)) ? cnt - JK_CNT_W'(1) : cnt;
      op_nx    = op;
      case (state)
         ST_INIT: begin
            // First cycle after reset the clear pin is still released;
            // only start counting once it is actually low.
            if (jk_clear_o)  cnt_nx   = cnt;
            else if (term)   state_nx = ST_IDLE;
         end
         ST_IDLE: begin
            if (accept) begin
               op_nx = cmd_op_i;
               if (cmd_op_i <= JK_OP_TOGGLE) state_nx = ST_SETUP;
               else if (!illegal) begin
                  state_nx = ST_ASYNC;
                  cnt_nx   = PULSE_LD;
               end else state_nx = ST_RESP;
            end
         end
         ST_SETUP: begin
            state_nx = ST_STROBE;
            cnt_nx   = PULSE_LD;
         end
         ST_STROBE, ST_ASYNC: begin
            if (term) begin
               state_nx = ST_SETTLE;
               cnt_nx   = SETTLE_LD;
            end
         end
         ST_SETTLE: if (term) state_nx = ST_CHECK;
         ST_CHECK:  state_nx = ST_RESP;
         ST_RESP:   if (rsp_ready_i) state_nx = ST_IDLE;
         default:   state_nx = ST_INIT;
      endcase
   end

   // State register, counter and op latch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_INIT;
         cnt   <= PULSE_LD;
         op    <= JK_OP_HOLD;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         op    <= op_nx;
      end
   end

   // Pin and status next values decoded from the upcoming state.
   always_comb begin
      jk_drive     = (state_nx == ST_SETUP || state_nx == ST_STROBE ||
                      state_nx == ST_SETTLE || state_nx == ST_CHECK) &&
                     (op_nx <= JK_OP_TOGGLE);
      j_nx         = jk_drive & op_nx[1];
      k_nx         = jk_drive & op_nx[0];
      clk_nx       = (state_nx != ST_STROBE);
      preset_nx    = !(state_nx == ST_ASYNC && op_nx == JK_OP_PRESET);
      clear_nx     = !(state_nx == ST_INIT ||
                       (state_nx == ST_ASYNC && op_nx == JK_OP_CLEAR));
      ready_nx     = (state_nx == ST_IDLE);
      rsp_valid_nx = (state_nx == ST_RESP);
      exp_q_nx     = exp_q;
      rsp_q_nx     = rsp_q_o;
      rsp_err_nx   = rsp_err_o;
      err_cnt_nx   = err_cnt_o;
      if (state == ST_CHECK) begin
         exp_q_nx   = jk_next(op, exp_q);
         rsp_q_nx   = jk_q_i;
         rsp_err_nx = (jk_q_i != exp_q_nx) | (jk_qn_i == jk_q_i);
      end
      if (state == ST_IDLE && accept && illegal) rsp_err_nx = 1'b1;
      if (state == ST_RESP && rsp_ready_i && rsp_err_o && !(&err_cnt_o))
         err_cnt_nx = err_cnt_o + ERR_CNT_W'(1);
   end

   // Registered pins, response fields, shadow Q and error counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         jk_j_o      <= 1'b0;
         jk_k_o      <= 1'b0;
         jk_clk_o    <= 1'b1;
         jk_preset_o <= 1'b1;
         jk_clear_o  <= 1'b1;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_q_o     <= 1'b0;
         rsp_err_o   <= 1'b0;
         err_cnt_o   <= '0;
         exp_q       <= 1'b0;
      end else begin
         jk_j_o      <= j_nx;
         jk_k_o      <= k_nx;
         jk_clk_o    <= clk_nx;
         jk_preset_o <= preset_nx;
         jk_clear_o  <= clear_nx;
         cmd_ready_o <= ready_nx;
         rsp_valid_o <= rsp_valid_nx;
         rsp_q_o     <= rsp_q_nx;
         rsp_err_o   <= rsp_err_nx;
         err_cnt_o   <= err_cnt_nx;
         exp_q       <= exp_q_nx;
      end
   end

endmodule
